// File: rtl/alu_serial_pkg.sv
// Shared definitions for the bit-serial ALU: op encodings, FSM states and op classifiers.
// Used by alu_serial_bit and alu_serial_seq.
package alu_serial_pkg;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_NOR  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd10;
    localparam logic [3:0] OP_SLT  = 4'd11;
    localparam logic [3:0] OP_SLT2 = 4'd12;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FIN
    } state_t;

    // Ops that run through the adder and therefore report carry and overflow.
    function automatic logic is_arith(input logic [3:0] ctrl);
        return (ctrl == OP_ADD) || (ctrl == OP_SUB) ||
               (ctrl == OP_SLT) || (ctrl == OP_SLT2);
    endfunction

    function automatic logic is_slt(input logic [3:0] ctrl);
        return (ctrl == OP_SLT) || (ctrl == OP_SLT2);
    endfunction

endpackage

// File: rtl/alu_serial_bit.sv
// Combinational 1-bit ALU slice used once per clock by the serial ALU.
// Optional NOR op enabled by defining ALU_SERIAL_NOR_EN.
module alu_serial_bit
    import alu_serial_pkg::*;
(
    input  logic [3:0] ctrl,
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    output logic       res,
    output logic       cout
);

    logic b_eff;

    always_comb begin
        // ctrl[3] selects subtract: B is inverted and the carry is pre-seeded by the caller.
        b_eff = b ^ ctrl[3];
        res   = 1'b0;
        cout  = 1'b0;
        case (ctrl)
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
`ifdef ALU_SERIAL_NOR_EN
            OP_NOR: res = ~(a | b);
`endif
            OP_ADD, OP_SUB, OP_SLT, OP_SLT2: begin
                res  = a ^ b_eff ^ cin;
                cout = (a & b_eff) | (a & cin) | (b_eff & cin);
            end
            default: begin
                res  = 1'b0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_serial_seq.sv
// Multi-cycle bit-serial ALU: one bit per clock, LSB first, start/done handshake.
// Optional NOR op (ctrl 4) enabled by defining ALU_SERIAL_NOR_EN.
module alu_serial_seq
    import alu_serial_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [3:0]       op_q;
    logic             carry;
    logic             cin_msb;
    logic             cout_msb;
    logic [CNT_W-1:0] cnt;
    logic             last_bit;
    logic             bit_res;
    logic             bit_cout;
    logic             fin_ovf;
    logic [WIDTH-1:0] fin_result;

    alu_serial_bit u_bit (
        .ctrl (op_q),
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .res  (bit_res),
        .cout (bit_cout)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign busy     = (state == SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // SLT reports the true sign of a-b, correcting the raw sum MSB when the subtraction overflowed.
    always_comb begin
        fin_ovf    = is_arith(op_q) & (cin_msb ^ cout_msb);
        fin_result = res_sh;
        if (is_slt(op_q)) begin
            fin_result = {{(WIDTH-1){1'b0}}, res_sh[WIDTH-1] ^ fin_ovf};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            op_q     <= '0;
            carry    <= 1'b0;
            cin_msb  <= 1'b0;
            cout_msb <= 1'b0;
            cnt      <= '0;
            done     <= 1'b0;
            result   <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        op_q  <= ctrl;
                        carry <= ctrl[3];
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= {bit_res, res_sh[WIDTH-1:1]};
                    carry  <= bit_cout;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        cin_msb  <= carry;
                        cout_msb <= bit_cout;
                    end
                end
                FIN: begin
                    result   <= fin_result;
                    carryout <= is_arith(op_q) & cout_msb;
                    overflow <= fin_ovf;
                    zero     <= (fin_result == '0);
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Scoreboard bench for alu_serial_seq at WIDTH=32.
module tb_alu_serial_seq;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] result;
        logic         carryout;
        logic         overflow;
        logic         zero;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [3:0]   ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carryout;
    logic         overflow;
    logic         zero;

    int   pass_cnt;
    int   total_cnt;
    exp_t sb_q[$];

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ctrl     (ctrl),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carryout (carryout),
        .overflow (overflow),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] op);
        exp_t       e;
        logic [W:0] s;
        e = '0;
        s = '0;
        case (op)
            4'd0: e.result = x & y;
            4'd1: e.result = x | y;
            4'd3: e.result = x ^ y;
`ifdef ALU_SERIAL_NOR_EN
            4'd4: e.result = ~(x | y);
`endif
            4'd2: begin
                s          = {1'b0, x} + {1'b0, y};
                e.result   = s[W-1:0];
                e.carryout = s[W];
                e.overflow = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
            end
            4'd10, 4'd11, 4'd12: begin
                s          = {1'b0, x} + {1'b0, ~y} + 33'd1;
                e.carryout = s[W];
                e.overflow = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
                e.result   = (op == 4'd10) ? s[W-1:0] : {{(W-1){1'b0}}, ($signed(x) < $signed(y))};
            end
            default: e.result = '0;
        endcase
        e.zero = (e.result == '0);
        return e;
    endfunction

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [3:0] ic);
        start = 1'b1;
        a     = ia;
        b     = ib;
        ctrl  = ic;
        @(posedge clk); #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        ctrl  = 4'($urandom);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done && n < 200);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        ctrl  = '0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({busy, done} !== 2'b00) $display("FAIL reset_busy_done: got %b%b expected 00", busy, done);
        else pass_cnt++;
        total_cnt++;
        if ({result, carryout, overflow, zero} !== {32'h0, 3'b001})
            $display("FAIL reset_outputs: got result=%h c=%b o=%b z=%b expected 0/0/0/1", result, carryout, overflow, zero);
        else pass_cnt++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        logic [W-1:0] va[2];
        logic [W-1:0] vb[2];
        exp_t         ve[2];
        exp_t         e;
        int           n;
        va = '{32'hFFFF_FFFF, 32'h7FFF_FFFF};
        vb = '{32'h0000_0001, 32'h0000_0001};
        ve = '{{32'h0000_0000, 1'b1, 1'b0, 1'b1}, {32'h8000_0000, 1'b0, 1'b1, 1'b0}};
        for (int i = 0; i < 2; i++) begin
            issue(va[i], vb[i], 4'd2);
            sb_q.push_back(ve[i]);
            total_cnt++;
            if (busy !== 1'b1) $display("FAIL add_busy_after_accept: got %b expected 1", busy);
            else pass_cnt++;
            wait_done(n);
            total_cnt++;
            if (n != 33) $display("FAIL add_latency: got %0d expected 33", n);
            else pass_cnt++;
            total_cnt++;
            if (busy !== 1'b0) $display("FAIL add_busy_at_done: got %b expected 0", busy);
            else pass_cnt++;
            e = sb_q.pop_front();
            total_cnt++;
            if ({result, carryout, overflow, zero} !== e)
                $display("FAIL add_result[%0d]: got %h c%b o%b z%b expected %h c%b o%b z%b", i,
                         result, carryout, overflow, zero, e.result, e.carryout, e.overflow, e.zero);
            else pass_cnt++;
            @(posedge clk); #1;
            total_cnt++;
            if (done !== 1'b0) $display("FAIL add_done_pulse: got %b expected 0", done);
            else pass_cnt++;
        end
    endtask

    task automatic test_sub_slt();
        logic [W-1:0] va[7];
        logic [W-1:0] vb[7];
        logic [3:0]   vc[7];
        exp_t         ve[7];
        exp_t         e;
        int           n;
        va = '{32'd5, 32'h8000_0000, 32'h8000_0000, 32'd1, 32'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        vb = '{32'd7, 32'd1, 32'd1, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        vc = '{4'd10, 4'd11, 4'd12, 4'd11, 4'd12, 4'd11, 4'd12};
        ve = '{{32'hFFFF_FFFE, 3'b000},
               {32'd1, 3'b110}, {32'd1, 3'b110},
               {32'd0, 3'b011}, {32'd0, 3'b011},
               {32'd0, 3'b011}, {32'd0, 3'b011}};
        for (int i = 0; i < 7; i++) begin
            issue(va[i], vb[i], vc[i]);
            sb_q.push_back(ve[i]);
            wait_done(n);
            total_cnt++;
            if (n != 33) $display("FAIL subslt_latency[%0d]: got %0d expected 33", i, n);
            else pass_cnt++;
            e = sb_q.pop_front();
            total_cnt++;
            if ({result, carryout, overflow, zero} !== e)
                $display("FAIL subslt_result[%0d] op%0d: got %h c%b o%b z%b expected %h c%b o%b z%b", i, vc[i],
                         result, carryout, overflow, zero, e.result, e.carryout, e.overflow, e.zero);
            else pass_cnt++;
        end
    endtask

    task automatic test_logic();
        logic [3:0] vc[6];
        exp_t       ve[6];
        exp_t       e;
        int         n;
        vc = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd7, 4'd8};
        ve[0] = {32'h00F0_0000, 3'b000};
        ve[1] = {32'hFFF0_FFFF, 3'b000};
        ve[2] = {32'hFF00_FFFF, 3'b000};
`ifdef ALU_SERIAL_NOR_EN
        ve[3] = {32'h000F_0000, 3'b000};
`else
        ve[3] = {32'h0000_0000, 3'b001};
`endif
        ve[4] = {32'h0000_0000, 3'b001};
        ve[5] = {32'h0000_0000, 3'b001};
        for (int i = 0; i < 6; i++) begin
            issue(32'hF0F0_A5A5, 32'h0FF0_5A5A, vc[i]);
            sb_q.push_back(ve[i]);
            wait_done(n);
            total_cnt++;
            if (n != 33) $display("FAIL logic_latency op%0d: got %0d expected 33", vc[i], n);
            else pass_cnt++;
            e = sb_q.pop_front();
            total_cnt++;
            if ({result, carryout, overflow, zero} !== e)
                $display("FAIL logic_result op%0d: got %h c%b o%b z%b expected %h c%b o%b z%b", vc[i],
                         result, carryout, overflow, zero, e.result, e.carryout, e.overflow, e.zero);
            else pass_cnt++;
        end
    endtask

    task automatic test_start_ignored();
        exp_t e;
        int   n;
        int   extra;
        issue(32'h1234_5678, 32'h1111_1111, 4'd2);
        sb_q.push_back({32'h2345_6789, 3'b000});
        repeat (10) @(posedge clk);
        #1;
        start = 1'b1;
        a     = 32'hFFFF_FFFF;
        b     = 32'hFFFF_FFFF;
        ctrl  = 4'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n);
        total_cnt++;
        if (n != 22) $display("FAIL ignored_start_latency: got %0d expected 22", n);
        else pass_cnt++;
        e = sb_q.pop_front();
        total_cnt++;
        if ({result, carryout, overflow, zero} !== e)
            $display("FAIL ignored_start_result: got %h c%b o%b z%b expected %h c%b o%b z%b",
                     result, carryout, overflow, zero, e.result, e.carryout, e.overflow, e.zero);
        else pass_cnt++;
        extra = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        total_cnt++;
        if (extra != 0) $display("FAIL ignored_start_single_done: got %0d extra dones expected 0", extra);
        else pass_cnt++;
    endtask

    task automatic test_rst_mid();
        exp_t         e;
        int           n;
        int           extra;
        logic [W-1:0] x;
        logic [W-1:0] y;
        issue(32'hDEAD_BEEF, 32'h0101_0101, 4'd2);
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total_cnt++;
        if ({busy, done, result, zero} !== {2'b00, 32'h0, 1'b1})
            $display("FAIL rst_mid_state: got busy%b done%b result %h z%b expected busy0 done0 result 0 z1",
                     busy, done, result, zero);
        else pass_cnt++;
        extra = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        total_cnt++;
        if (extra != 0) $display("FAIL rst_mid_no_done: got %0d dones expected 0", extra);
        else pass_cnt++;
        x = 32'h0000_00FF;
        y = 32'h0000_0F00;
        issue(x, y, 4'd10);
        sb_q.push_back(model(x, y, 4'd10));
        wait_done(n);
        total_cnt++;
        if (n != 33) $display("FAIL rst_mid_restart_latency: got %0d expected 33", n);
        else pass_cnt++;
        e = sb_q.pop_front();
        total_cnt++;
        if ({result, carryout, overflow, zero} !== e)
            $display("FAIL rst_mid_restart_result: got %h c%b o%b z%b expected %h c%b o%b z%b",
                     result, carryout, overflow, zero, e.result, e.carryout, e.overflow, e.zero);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [3:0]   ops[9];
        logic [3:0]   op;
        logic [W-1:0] x;
        logic [W-1:0] y;
        exp_t         e;
        int           n;
        ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd10, 4'd11, 4'd12, 4'd6};
        for (int i = 0; i < 12; i++) begin
            op = ops[$urandom_range(0, 8)];
            x  = $urandom;
            y  = $urandom;
            if (i == 0) y = x;
            issue(x, y, op);
            sb_q.push_back(model(x, y, op));
            wait_done(n);
            total_cnt++;
            if (n != 33) $display("FAIL b2b_latency[%0d]: got %0d expected 33", i, n);
            else pass_cnt++;
            e = sb_q.pop_front();
            total_cnt++;
            if ({result, carryout, overflow, zero} !== e)
                $display("FAIL b2b_result[%0d] op%0d a=%h b=%h: got %h c%b o%b z%b expected %h c%b o%b z%b",
                         i, op, x, y, result, carryout, overflow, zero, e.result, e.carryout, e.overflow, e.zero);
            else pass_cnt++;
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_add();
        test_sub_slt();
        test_logic();
        test_start_ignored();
        test_rst_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/alu_serial_seq.md
Name: alu_serial_seq

Overview:
- Multi-cycle, bit-serial ALU that issues the same 4-bit Ctrl op encoding that the 1-bit ALU slice consumes.
- Accepts a WIDTH-bit operand pair and an op on a start/done handshake.
- Processes one bit per clock, LSB first, with a registered carry, and returns the WIDTH-bit result, carry, zero and overflow flags.
- Serves as an area-reduced EX-stage alternative for the pipelined MIPS core, and as a golden serial model for slice-chain checking.

Parameters:
- WIDTH, 32, operand/result width in bits (≥2).
- CNT_W, $clog2(WIDTH), bit-counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- ctrl  input  4  op: 0 AND, 1 OR, 2 ADD, 3 XOR, 10 SUB, 11 SLT, 12 SLT.
- a  input  WIDTH  operand A; captured on the accepted start.
- b  input  WIDTH  operand B; captured on the accepted start.
- busy  output  1  high from the accept cycle+1 through the last bit cycle.
- done  output  1  one-cycle pulse; result and flags valid.
- result  output  WIDTH  final result; held until the next accept.
- carryout  output  1  carry out of the MSB bit (ADD/SUB/SLT), else 0.
- overflow  output  1  signed overflow of ADD/SUB/SLT, else 0.
- zero  output  1  result == 0.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high.
- Reset values: state=IDLE; busy, done, result, carryout, overflow = 0; zero = 1.
- Reset mid-operation aborts to IDLE; no done pulse is issued.
- States: IDLE → SHIFT → FIN → IDLE.
- IDLE:
  - On start=1, latch a, b and ctrl into shift registers, clear the bit counter, and go to SHIFT.
  - Carry register is loaded with ctrl[3] (1 for SUB/SLT, 0 otherwise).
- SHIFT, one bit per cycle (counter 0..WIDTH-1):
  - Bit op uses a[0], b[0] and carry. SUB/SLT use ~b.
  - Sum bit = a^b'^c; new carry = majority(a,b',c).
  - Result bit is shifted in at the MSB and the operand registers shift right.
  - At counter == WIDTH-1:
    - record MSB carry-in (for overflow) and carry-out;
    - go to FIN.
- FIN (1 cycle):
  - Assemble result.
  - overflow = cin_msb ^ cout_msb.
  - SLT (11 or 12): result = {WIDTH-1 zeros, sum_msb ^ overflow}.
  - Set zero; pulse done=1; go to IDLE.
- Latency: start accepted at cycle 0 → done at cycle WIDTH+1. Back-to-back start is allowed on the cycle after done.
- start while busy or in FIN is ignored; no queuing.
- Illegal ctrl: result=0, carryout=0, overflow=0, zero=1; timing is unchanged.
- For AND/OR/XOR: carryout=0, overflow=0.
- a/b/ctrl changes after accept have no effect.

Optional Feature:
- Macro: ALU_SERIAL_NOR_EN.
- Defined: ctrl=4'b0100 is NOR, result bit = ~(a|b); flags are as for logic ops.
- Undefined: 4'b0100 is illegal (result 0, zero 1).

Decomposition:
- Package alu_serial_pkg:
  - ctrl localparams: OP_AND, OP_OR, OP_ADD, OP_XOR, OP_SUB, OP_SLT, OP_SLT2, OP_NOR;
  - state enum IDLE/SHIFT/FIN;
  - helper function is_arith(ctrl).
- One sub-module, alu_serial_bit: combinational 1-bit op (ctrl, a, b, cin → res, cout). The carry flop, shift registers and FSM stay in the top.

Test Plan (WIDTH=32):
- ADD: 0xFFFFFFFF + 0x00000001 → result 0, carryout 1, zero 1, overflow 0; done exactly 33 cycles after accept.
- SUB: 5 − 7 → result 0xFFFFFFFE, carryout 0, zero 0. ADD 0x7FFFFFFF + 1 → 0x80000000, overflow 1.
- SLT (ctrl 11 and 12):
  - 0x80000000 vs 1 → result 1;
  - 1 vs 0x80000000 → result 0;
  - 0x7FFFFFFF vs 0x80000000 (overflow case) → result 0.
- Logic ops on 0xF0F0A5A5 / 0x0FF05A5A:
  - AND → 0x00F00000; OR → 0xFFF0FFFF; XOR → 0xFF00FFFF;
  - ctrl 4 → 0x000F0000 with ALU_SERIAL_NOR_EN, 0 without.
- start pulsed at counter 10 of an ADD with new operands → ignored; original result delivered; single done.
- rst asserted at counter 15 → next cycle busy=0, result=0, zero=1, no done; a new start then completes normally.
